// File: rtl/modulator.sv
// Splits each captured N_SYM*SYM_W message into N_SYM symbols on a valid/ready stream.
// Symbol 0 is the low slice; a new message may be captured on the final transfer.
module modulator #(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned N_SYM = 4,
  localparam int unsigned MSG_W = N_SYM * SYM_W,
  localparam int unsigned IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req,
  input  logic [MSG_W-1:0] data_in,
  output logic             ack,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [SYM_W-1:0] sym_out,
  output logic [IDX_W-1:0] sym_idx,
  output logic             sym_last,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_SYM - 1);

  state_e           state_q, state_d;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ack_q;
  logic             capture;
  logic             xfer;
  logic             at_last;

  assign xfer    = (state_q == StSend) && sym_ready;
  assign at_last = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (req && en) begin
          capture = 1'b1;
          shift_d = data_in;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          if (!at_last) begin
            shift_d = shift_q >> SYM_W;
            idx_d   = idx_q + IDX_W'(1);
          end else if (req && en) begin
            // Back-to-back capture on the final transfer keeps the stream gap-free.
            capture = 1'b1;
            shift_d = data_in;
            idx_d   = '0;
          end else begin
            shift_d = '0;
            idx_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ack_q   <= capture;
    end
  end

  assign ack       = ack_q;
  assign sym_valid = (state_q == StSend);
  assign busy      = sym_valid;
  assign sym_out   = sym_valid ? shift_q[SYM_W-1:0] : '0;
  assign sym_idx   = idx_q;
  assign sym_last  = sym_valid && at_last;

endmodule

// File: doc/modulator.md
# modulator

Transmit-side counterpart of the symbol demodulator in the FEC codec path. Accepts one encoded message per request from upstream and splits it into N_SYM modulated symbols. Emits those symbols one per accepted transfer on a valid/ready stream toward the channel side. Symbol order lets the receive side rebuild the original message by concatenating symbol 3..0.

## Interface
- SYM_W, 2, bits per modulated symbol; equals the width of encoder_fec_pkg::modulated_message_data_t.
- N_SYM, 4, symbols per message, at least 2; message width is N_SYM*SYM_W and equals demodulated_message_data_t.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  acceptance enable; gates capture of new messages only.
- req  in  1  upstream message request, level; data_in valid while high.
- data_in  in  N_SYM*SYM_W  message; symbol k = data_in[k*SYM_W +: SYM_W].
- ack  out  1  registered one-cycle pulse, cycle after capture.
- sym_valid  out  1  sym_out holds a valid symbol.
- sym_ready  in  1  downstream accepts; transfer = sym_valid & sym_ready.
- sym_out  out  SYM_W  current symbol.
- sym_idx  out  clog2(N_SYM)  index of current symbol.
- sym_last  out  1  sym_valid and sym_idx == N_SYM-1.
- busy  out  1  high in SEND.

## Operation
- Reset values: state IDLE, ack 0, sym_valid 0, sym_out 0, sym_idx 0, sym_last 0, busy 0, shift register 0.
- IDLE: if req & en at an edge, capture data_in into a shift register, set sym_idx = 0, go to SEND, set ack = 1 for the next cycle only.
- SEND:
  - sym_valid = 1 and sym_out = shift register [SYM_W-1:0].
  - On each transfer, shift right by SYM_W and increment sym_idx.
  - On the transfer with sym_idx == N_SYM-1:
    - If req & en are high in the same cycle, capture the new message directly. Stay in SEND, set sym_idx = 0, pulse ack. No bubble.
    - Otherwise go to IDLE and drop sym_valid.
- No transfer (sym_ready low): sym_out, sym_idx and sym_valid hold stable. sym_valid never drops mid-message.
- en low in SEND does not stall the symbol stream. It only blocks the back-to-back capture, so the block returns to IDLE.
- req high in SEND, other than at the last-symbol transfer: ignored, no ack.
- ack is never high for two consecutive cycles. Exactly one ack per captured message.
- Upstream must drop req or present the next message in the cycle ack is seen. A req still high after ack's cycle is a new request.
- Reset mid-message: the partial message is discarded and all outputs return to their reset values immediately. No symbols are emitted after reset release until a new capture.

## Timing
- Capture at edge T: ack and sym_valid high with symbol 0 during cycle T+1.
- Minimum occupancy is N_SYM cycles per message with sym_ready held high. Sustained throughput is 1 message per N_SYM cycles with back-to-back req.
- Capture-to-last-symbol latency with sym_ready high: symbol k is presented in cycle T+1+k.
- busy equals sym_valid.

## Test plan
- Reset, then req=1, en=1, data_in=8'hB4, sym_ready=1:
  - ack is high for exactly one cycle.
  - sym_out sequence is 2'b00, 2'b01, 2'b11, 2'b10 with sym_idx 0..3.
  - sym_last is high on idx 3 only, then sym_valid drops.
- Same message with sym_ready toggled 1,0,0,1,0,1,1: each symbol is held stable while stalled, the order is unchanged, and exactly 4 transfers occur.
- req held high with data 8'hB4 then 8'h1E presented after the first ack:
  - The second capture coincides with the last transfer of the first message.
  - Output is 00,01,11,10,10,11,01,00 with no gap.
  - Two ack pulses occur, 4 cycles apart.
- en=0 with req=1: no ack and no sym_valid. Raise en: capture on the next edge.
- en dropped during SEND: the current message completes and the block returns to IDLE, with no capture.
- Assert rst after the second transfer: all outputs are 0 immediately. After release and no req, sym_valid stays 0.
